// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, control-bit layout,
// control encodings and the immediate formats with their bit gathering.
package id_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_ALU_OP_HI  = 2;
  localparam int CTRL_ALU_OP_LO  = 1;
  localparam int CTRL_ALU_SRC    = 0;

  localparam logic [7:0] CTRL_R      = 8'h84;
  localparam logic [7:0] CTRL_I      = 8'h85;
  localparam logic [7:0] CTRL_LOAD   = 8'hD1;
  localparam logic [7:0] CTRL_STORE  = 8'h09;
  localparam logic [7:0] CTRL_BRANCH_ENC = 8'h22;
  localparam logic [7:0] CTRL_LUI    = 8'h81;
  localparam logic [7:0] CTRL_JAL    = 8'hA0;
  localparam logic [7:0] CTRL_NONE   = 8'h00;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  // Returns the 32-bit sign-extended immediate; callers widen it to XLEN.
  function automatic logic [31:0] gen_imm32(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two read ports, one write port, x0 hardwired
// to zero, out-of-range indices read as zero, same-cycle write-through.
module id_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  input  logic [4:0]      rd_addr_b,
  output logic [XLEN-1:0] rd_data_b
);

  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] LIMIT = 6'(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;

  assign wr_ok = wr_en && (wr_addr != 5'd0) && ({1'b0, wr_addr} < LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // A write landing this cycle is forwarded so the reader sees the new value.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0] data;
    data = '0;
    if ((addr != 5'd0) && ({1'b0, addr} < LIMIT)) begin
      if (wr_ok && (wr_addr == addr)) begin
        data = wr_data;
      end else begin
        data = regs[addr[AW-1:0]];
      end
    end
    return data;
  endfunction

  assign rd_data_a = read_port(rd_addr_a);
  assign rd_data_b = read_port(rd_addr_b);

endmodule

// File: rtl/id_decode_pipe.sv
// Instruction decode stage: decodes control and immediates, reads operands
// and registers the result behind a valid/ready handshake with load-use stall.
module id_decode_pipe
  import id_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [7:0]      out_ctrl,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_illegal
);

  localparam logic [5:0] LIMIT = 6'(NREGS);

  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [7:0]        ctrl;
  imm_fmt_t          fmt;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              bad_op;
  logic              bad_index;
  logic              illegal;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              hazard;
  logic              accept;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  always_comb begin
    ctrl     = CTRL_NONE;
    fmt      = IMM_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    bad_op   = 1'b0;
    case (opcode)
      OP_R:      begin ctrl = CTRL_R;          fmt = IMM_NONE; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_I:      begin ctrl = CTRL_I;          fmt = IMM_I;    uses_rs1 = 1'b1; end
      OP_LOAD:   begin ctrl = CTRL_LOAD;       fmt = IMM_I;    uses_rs1 = 1'b1; end
      OP_STORE:  begin ctrl = CTRL_STORE;      fmt = IMM_S;    uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: begin ctrl = CTRL_BRANCH_ENC; fmt = IMM_B;    uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_LUI:    begin ctrl = CTRL_LUI;        fmt = IMM_U;    end
      OP_JAL:    begin ctrl = CTRL_JAL;        fmt = IMM_J;    end
      default:   bad_op = 1'b1;
    endcase
  end

  // Only operand fields the opcode actually reads can make it illegal.
  assign bad_index = (uses_rs1 && ({1'b0, rs1} >= LIMIT)) ||
                     (uses_rs2 && ({1'b0, rs2} >= LIMIT));
  assign illegal   = bad_op || bad_index;

  assign imm32 = gen_imm32(in_instr, fmt);
  assign imm   = XLEN'(imm32);

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wb_en),
    .wr_addr   (wb_rd),
    .wr_data   (wb_data),
    .rd_addr_a (rs1),
    .rd_data_a (rs1_data),
    .rd_addr_b (rs2),
    .rd_data_b (rs2_data)
  );

  // A load still sitting in the output stage cannot feed the next instruction.
  assign hazard = HAZARD_EN && out_valid && out_ctrl[CTRL_MEM_READ] && (out_rd != 5'd0) &&
                  ((out_rd == rs1) || ((out_rd == rs2) && uses_rs2));

  assign in_ready = (out_ready || !out_valid) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_ctrl     <= '0;
      out_funct3   <= '0;
      out_funct7   <= '0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_imm      <= imm;
      out_ctrl     <= ctrl;
      out_funct3   <= funct3;
      out_funct7   <= funct7;
      out_rd       <= rd;
      out_rs1      <= rs1;
      out_rs2      <= rs2;
      out_illegal  <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed plus randomized check of id_decode_pipe against a cycle-level
// reference model; a second XLEN=64 instance checks immediate widening.
module tb_id_decode_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [7:0]  out_ctrl;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_illegal;

  logic [63:0] in_pc64, wb_data64;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_pc64, out_rs1_data64, out_rs2_data64, out_imm64;
  logic [7:0]  out_ctrl64;
  logic [2:0]  out_funct3_64;
  logic [6:0]  out_funct7_64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  assign in_pc64   = {32'h0, in_pc};
  assign wb_data64 = {32'h0, wb_data};

  id_decode_pipe #(.XLEN(32), .NREGS(32), .HAZARD_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_illegal(out_illegal)
  );

  id_decode_pipe #(.XLEN(64), .NREGS(32), .HAZARD_EN(1'b1)) dut64 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_pc(in_pc64), .in_instr(in_instr), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data64), .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
    .out_rs1_data(out_rs1_data64), .out_rs2_data(out_rs2_data64), .out_imm(out_imm64),
    .out_ctrl(out_ctrl64), .out_funct3(out_funct3_64), .out_funct7(out_funct7_64),
    .out_rd(out_rd64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_illegal(out_illegal64)
  );

  // Reference model state: register file and the expected output stage.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm, m_instr;
  logic [7:0]  m_ctrl;
  logic        m_ill;
  logic        last_ready;

  function automatic logic [7:0] exp_ctrl(input logic [6:0] op);
    case (op)
      7'h33:   return 8'h84;
      7'h13:   return 8'h85;
      7'h03:   return 8'hD1;
      7'h23:   return 8'h09;
      7'h63:   return 8'h22;
      7'h37:   return 8'h81;
      7'h6F:   return 8'hA0;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit exp_known(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F};
  endfunction

  function automatic bit exp_uses_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  // Immediates computed arithmetically from the signed instruction word.
  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    int s;
    s = $signed(ins);
    case (ins[6:0])
      7'h13, 7'h03: return 32'(s >>> 20);
      7'h23:        return 32'((s >>> 25) * 32 + int'(ins[11:7]));
      7'h63:        return 32'((s >>> 31) * 4096 + int'(ins[7]) * 2048 +
                               int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
      7'h37:        return ins & 32'hFFFFF000;
      7'h6F:        return 32'((s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 +
                               int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (we && (wrd == idx)) return wd;
    return m_regs[idx];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0; m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
    m_instr = '0; m_ctrl = '0; m_ill = 1'b0;
  endtask

  task automatic check_output();
    chk("out_valid", out_valid, m_valid);
    chk("out_pc", out_pc, m_pc);
    chk("out_rs1_data", out_rs1_data, m_rs1d);
    chk("out_rs2_data", out_rs2_data, m_rs2d);
    chk("out_imm", out_imm, m_imm);
    chk("out_ctrl", out_ctrl, m_ctrl);
    chk("out_funct3", out_funct3, m_instr[14:12]);
    chk("out_funct7", out_funct7, m_instr[31:25]);
    chk("out_rd", out_rd, m_instr[11:7]);
    chk("out_rs1", out_rs1, m_instr[19:15]);
    chk("out_rs2", out_rs2, m_instr[24:20]);
    chk("out_illegal", out_illegal, m_ill);
  endtask

  // One clock of stimulus; starts and ends just after a rising edge.
  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                input logic fl, input logic we, input logic [4:0] wrd,
                                input logic [31:0] wd, input logic ordy);
    logic hz, rdy;
    logic [4:0] mrd;
    in_valid = v; in_pc = pc; in_instr = ins; flush = fl;
    wb_en = we; wb_rd = wrd; wb_data = wd; out_ready = ordy;
    #1;
    mrd = m_instr[11:7];
    hz  = m_valid && m_ctrl[4] && (mrd != 5'd0) &&
          ((mrd == ins[19:15]) || ((mrd == ins[24:20]) && exp_uses_rs2(ins[6:0])));
    rdy = (ordy || !m_valid) && !hz;
    last_ready = in_ready;
    chk("in_ready", in_ready, rdy);
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && rdy) begin
      m_valid = 1'b1;
      m_pc    = pc;
      m_instr = ins;
      m_ctrl  = exp_ctrl(ins[6:0]);
      m_imm   = exp_imm(ins);
      m_ill   = !exp_known(ins[6:0]);
      m_rs1d  = model_read(ins[19:15], we, wrd, wd);
      m_rs2d  = model_read(ins[24:20], we, wrd, wd);
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (we && (wrd != 5'd0)) m_regs[wrd] = wd;
    @(posedge clock);
    #1;
    check_output();
  endtask

  task automatic idle(input logic ordy);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, ordy);
  endtask

  logic [31:0] rnd_ins;
  logic [6:0]  ops [8];
  logic [31:0] held_pc;

  initial begin
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;
    ops[4] = 7'h63; ops[5] = 7'h37; ops[6] = 7'h6F; ops[7] = 7'h7F;
    model_reset();
    last_ready = 1'b0;

    // Reset state, then release.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, 8'h00);
    chk("rst_out_illegal", out_illegal, 1'b0);
    chk("rst_out_imm", out_imm, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // x1 = 5, then addi x1,x1,0.
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'h5, 1'b1);
    apply_stimulus(1'b1, 32'h100, 32'h00008093, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("addi_ctrl", out_ctrl, 8'h85);
    chk("addi_imm", out_imm, 32'h0);
    chk("addi_rs1_data", out_rs1_data, 32'h5);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi64_ctrl", out_ctrl64, 8'h85);
    chk("addi64_rs1_data", out_rs1_data64, 64'h5);

    // Store and an illegal opcode.
    apply_stimulus(1'b1, 32'h104, 32'h0010A0A3, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("store_ctrl", out_ctrl, 8'h09);
    chk("store_imm", out_imm, 32'h1);
    chk("store_funct3", out_funct3, 3'd2);
    apply_stimulus(1'b1, 32'h108, 32'h0000007F, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("illegal_ctrl", out_ctrl, 8'h00);
    chk("illegal_flag", out_illegal, 1'b1);

    // lw x5 followed by dependent addi x10,x5,62: one bubble.
    apply_stimulus(1'b1, 32'h10C, 32'h0030A283, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("lw_ctrl", out_ctrl, 8'hD1);
    apply_stimulus(1'b1, 32'h110, 32'h03E28513, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("hazard_in_ready", last_ready, 1'b0);
    chk("bubble_valid", out_valid, 1'b0);
    apply_stimulus(1'b1, 32'h110, 32'h03E28513, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("after_bubble_ready", last_ready, 1'b1);
    chk("dep_valid", out_valid, 1'b1);
    chk("dep_imm", out_imm, 32'd62);
    chk("dep_rd", out_rd, 5'd10);

    // Write-through of x2, and a write to x0 that must not stick.
    apply_stimulus(1'b1, 32'h114, 32'h00010193, 1'b0, 1'b1, 5'd2, 32'hA5, 1'b1);
    chk("bypass_rs1_data", out_rs1_data, 32'hA5);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFF, 1'b1);
    apply_stimulus(1'b1, 32'h118, 32'h00000213, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("x0_reads_zero", out_rs1_data, 32'h0);

    // Back-pressure for 3 cycles, then flush.
    held_pc = out_pc;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h200 + 32'(i), 32'h00100093, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("stall_in_ready", last_ready, 1'b0);
    end
    chk("stall_pc_held", out_pc, held_pc);
    apply_stimulus(1'b1, 32'h300, 32'h00100093, 1'b1, 1'b1, 5'd3, 32'h33, 1'b0);
    chk("flush_valid", out_valid, 1'b0);

    // 64-bit widening of a negative immediate: addi x1,x0,-1.
    apply_stimulus(1'b1, 32'h304, 32'hFFF00093, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("neg_imm32", out_imm, 32'hFFFFFFFF);
    chk("neg_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("neg_ctrl64", out_ctrl64, 8'h85);

    // Randomized traffic with small register indices to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      rnd_ins = $urandom();
      rnd_ins[6:0]   = ops[$urandom_range(0, 7)];
      rnd_ins[11:7]  = 5'($urandom_range(0, 7));
      rnd_ins[19:15] = 5'($urandom_range(0, 7));
      rnd_ins[24:20] = 5'($urandom_range(0, 7));
      apply_stimulus(1'($urandom_range(0, 3) != 0), $urandom(), rnd_ins,
                     1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 3) != 0));
    end

    // Reset mid-transfer discards the beat and clears everything.
    in_valid = 1'b1; in_instr = 32'h0030A283; in_pc = 32'h400; out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ctrl", out_ctrl, 8'h00);
    chk("midrst_pc", out_pc, 32'h0);
    @(posedge clock);
    #1;
    chk("midrst_hold_valid", out_valid, 1'b0);
    reset_n = 1'b1;
    model_reset();
    apply_stimulus(1'b1, 32'h500, 32'h00008093, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("post_rst_x1_zero", out_rs1_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
